// File: rtl/ahblite_pkg.sv
// Shared AHB-Lite encodings and slave state type for the wait-state SRAM responder.
// No logic of its own; the lane-mask helper is purely combinational.
// No flow control here; users apply HREADY/HREADYOUT handshaking.
package ahblite_pkg;

  // HTRANS transfer types; bit 1 set means a real (NONSEQ/SEQ) transfer
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // HSIZE codes supported by a 32-bit slave; anything larger is an error
  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  // HRESP values
  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Slave data-phase state
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DONE = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } slave_state_e;

  // Byte-lane write mask for an already-validated (aligned, <= word) access.
  // size is the low two HSIZE bits; addr_lo is the byte offset in the word.
  function automatic logic [3:0] byte_lanes(input logic [1:0] size, input logic [1:0] addr_lo);
    logic [3:0] mask;
    mask = 4'b0000;
    case (size)
      2'd0:    mask = 4'b0001 << addr_lo;
      2'd1:    mask = addr_lo[1] ? 4'b1100 : 4'b0011;
      default: mask = 4'b1111;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/ahblite_wait_sram_mem.sv
// DEPTH x 32 word storage with a byte-enable write port and combinational read.
// Write takes effect on the rising edge; read data follows the index the same cycle.
// No backpressure; the owning FSM decides when to write and when read data is valid.
module ahblite_wait_sram_mem #(
  parameter int DEPTH = 256,
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             we,
  input  logic [3:0]       be,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  // Contents are deliberately not reset; software must initialise what it reads.
  logic [31:0] mem_q [DEPTH];

  // Byte-lane write: only enabled lanes of the addressed word change
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  // Read port is asynchronous so a write committed on one edge is visible next cycle
  assign rdata = mem_q[idx];

endmodule

// File: rtl/ahblite_wait_sram.sv
// AHB-Lite SRAM responder with WAIT_STATES wait cycles and a two-cycle ERROR path.
// OKAY data phase lasts WAIT_STATES+1 cycles; ERROR data phase lasts exactly 2 cycles.
// Stalls the bus via HREADYOUT=0 in WAIT and ERR1; accepts only when HREADY is high.
module ahblite_wait_sram
  import ahblite_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 1,
  parameter int ADDR_WIDTH  = 12
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  output logic        HRESP
);

  localparam int         IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int         AQ_W    = IDX_W + 2;
  localparam logic [3:0] WS_INIT = 4'(WAIT_STATES);

  // Registered data-phase context
  slave_state_e    state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [AQ_W-1:0] addr_q, addr_d;
  logic [1:0]      size_q, size_d;
  logic            write_q, write_d;

  // Address-phase decode
  logic                  accept;
  logic                  can_accept;
  logic                  align_err;
  logic                  range_err;
  logic                  xfer_err;
  logic [ADDR_WIDTH-3:0] word_off;

  // Memory port
  logic             mem_we;
  logic [3:0]       mem_be;
  logic [IDX_W-1:0] mem_idx;
  logic [31:0]      mem_rdata;

  // Upper address bits are decoded by the interconnect; HTRANS[0] only splits NONSEQ/SEQ
  logic unused_ok;
  assign unused_ok = &{1'b0, HADDR[31:ADDR_WIDTH], HTRANS[0]};

  // A new address phase can only land while this slave is not stalling the bus
  assign can_accept = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR2);
  assign accept     = HSEL && HTRANS[1] && HREADY && can_accept;

  // Word offset beyond the array is an error even if it is within the decoded window
  assign word_off  = HADDR[ADDR_WIDTH-1:2];
  assign range_err = (32'(word_off) >= 32'(DEPTH));

  // Size/alignment legality of the incoming transfer
  always_comb begin
    align_err = 1'b0;
    case (HSIZE)
      HSIZE_BYTE: align_err = 1'b0;
      HSIZE_HALF: align_err = HADDR[0];
      HSIZE_WORD: align_err = |HADDR[1:0];
      default:    align_err = 1'b1;
    endcase
  end

  assign xfer_err = align_err || range_err;

  // Next-state: finish the current data phase, then let a same-cycle accept override
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    size_d  = size_q;
    write_d = write_q;

    case (state_q)
      ST_WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d = ST_DONE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      ST_DONE: state_d = ST_IDLE;
      ST_ERR2: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Pipelined accept: the completing phase ends on this edge, the new one starts
    if (accept) begin
      addr_d  = HADDR[AQ_W-1:0];
      size_d  = HSIZE[1:0];
      write_d = HWRITE;
      if (xfer_err) begin
        state_d = ST_ERR1;
        cnt_d   = 4'd0;
      end else if (WAIT_STATES == 0) begin
        state_d = ST_DONE;
        cnt_d   = 4'd0;
      end else begin
        state_d = ST_WAIT;
        cnt_d   = WS_INIT;
      end
    end
  end

  // Control and context registers; reset abandons any transfer in flight
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      size_q  <= 2'd0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      write_q <= write_d;
    end
  end

  // Only a validated transfer reaches DONE, so the error path never writes.
  // An asynchronous reset drops state_q out of DONE and so also kills the write.
  assign mem_we  = (state_q == ST_DONE) && write_q;
  assign mem_be  = byte_lanes(size_q, addr_q[1:0]);
  assign mem_idx = addr_q[AQ_W-1:2];

  ahblite_wait_sram_mem #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_mem (
    .clk   (HCLK),
    .we    (mem_we),
    .be    (mem_be),
    .idx   (mem_idx),
    .wdata (HWDATA),
    .rdata (mem_rdata)
  );

  // Bus outputs are decoded from state so reset forces them immediately
  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = HRESP_OKAY;
    HRDATA    = 32'h0;
    case (state_q)
      ST_WAIT: HREADYOUT = 1'b0;
      ST_DONE: HRDATA    = write_q ? 32'h0 : mem_rdata;
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = HRESP_ERROR;
      end
      ST_ERR2: HRESP = HRESP_ERROR;
      default: HREADYOUT = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_ahblite_wait_sram.sv
// Bench for ahblite_wait_sram: one instance with two wait states, one with none.
// Expected completions are queued at issue time and retired by a bus monitor.
// The bench HREADY follows whichever instance is currently addressed.
module tb_ahblite_wait_sram;
  import ahblite_pkg::*;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        hsel;
  logic        use0;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic [31:0] HWDATA;

  logic        ro2, ro0, rs2, rs0;
  logic [31:0] rd2, rd0;
  logic        hready_bus, hresp_bus;
  logic [31:0] hrdata_bus;

  assign hready_bus = use0 ? ro0 : ro2;
  assign hresp_bus  = use0 ? rs0 : rs2;
  assign hrdata_bus = use0 ? rd0 : rd2;

  always #5 HCLK = ~HCLK;

  ahblite_wait_sram #(.DEPTH(256), .WAIT_STATES(2), .ADDR_WIDTH(12)) dut2 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel & ~use0), .HADDR(HADDR), .HTRANS(HTRANS),
    .HSIZE(HSIZE), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(hready_bus),
    .HREADYOUT(ro2), .HRDATA(rd2), .HRESP(rs2)
  );

  ahblite_wait_sram #(.DEPTH(256), .WAIT_STATES(0), .ADDR_WIDTH(12)) dut0 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel & use0), .HADDR(HADDR), .HTRANS(HTRANS),
    .HSIZE(HSIZE), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(hready_bus),
    .HREADYOUT(ro0), .HRDATA(rd0), .HRESP(rs0)
  );

  typedef struct {
    logic        rd;
    logic        resp;
    logic [31:0] data;
    int          waits;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] mdl [2][256];
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive one address phase, queue its expected completion, then hold its write data
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                       input logic [31:0] wd, input logic [1:0] trans, input logic push);
    exp_t       e;
    int         sel;
    int         guard;
    logic       err;
    logic [7:0] idx;
    sel = use0 ? 1 : 0;
    idx = addr[9:2];
    err = (size > 3'd2) || (size == 3'd1 && addr[0]) ||
          (size == 3'd2 && addr[1:0] != 2'b00) || (addr[11:2] >= 10'd256);
    if (push) begin
      e.rd    = !wr;
      e.resp  = err;
      e.data  = 32'h0;
      e.waits = err ? 1 : (use0 ? 0 : 2);
      if (!err && wr) begin
        for (int l = 0; l < 4; l++) begin
          logic en;
          en = (size == 3'd2) || (size == 3'd1 && (l[1] == addr[1])) ||
               (size == 3'd0 && (l[1:0] == addr[1:0]));
          if (en) mdl[sel][idx][8*l +: 8] = wd[8*l +: 8];
        end
      end
      if (!err && !wr) e.data = mdl[sel][idx];
      sb_q.push_back(e);
    end
    hsel   = 1'b1;
    HTRANS = trans;
    HADDR  = addr;
    HWRITE = wr;
    HSIZE  = size;
    guard  = 0;
    forever begin
      @(negedge HCLK);
      if (hready_bus) break;
      guard++;
      if (guard > 40) begin
        check("accept_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge HCLK);
    #1;
    HWDATA = wd;
    hsel   = 1'b0;
    HTRANS = HTRANS_IDLE;
  endtask

  // Selected but non-transferring cycles (IDLE or BUSY)
  task automatic idle_sel(input int n, input logic [1:0] trans);
    hsel   = 1'b1;
    HTRANS = trans;
    repeat (n) begin
      @(posedge HCLK);
      #1;
    end
    hsel   = 1'b0;
    HTRANS = HTRANS_IDLE;
  endtask

  logic dp_active  = 1'b0;
  int   lowcnt     = 0;
  logic first_resp = 1'b0;

  // Wait for every queued completion to retire
  task automatic drain();
    int guard = 0;
    hsel   = 1'b0;
    HTRANS = HTRANS_IDLE;
    while (dp_active || sb_q.size() != 0) begin
      @(posedge HCLK);
      #1;
      guard++;
      if (guard > 40) begin
        check("drain_timeout", 32'(sb_q.size()), 32'd0);
        sb_q.delete();
        break;
      end
    end
  endtask

  // Bus monitor: tracks the data phase and retires expectations on completion
  always @(negedge HCLK) begin : monitor
    logic act;
    int   lc;
    logic fr;
    exp_t e;
    act = dp_active;
    lc  = lowcnt;
    fr  = first_resp;
    if (HRESET) begin
      act = 1'b0;
      lc  = 0;
    end else begin
      if (act) begin
        if (!hready_bus) begin
          lc++;
          if (lc == 1) fr = hresp_bus;
          check("hrdata_wait", hrdata_bus, 32'h0);
        end else begin
          if (sb_q.size() == 0) begin
            check("sb_underflow", 32'(sb_q.size()), 32'd1);
          end else begin
            e = sb_q.pop_front();
            check("resp", 32'(hresp_bus), 32'(e.resp));
            check("waits", lc, e.waits);
            if (e.resp) check("err1_resp", 32'(fr), 32'd1);
            else if (e.rd) check("rdata", hrdata_bus, e.data);
          end
          act = 1'b0;
        end
      end
      if (!act && hsel && HTRANS[1] && hready_bus) begin
        act = 1'b1;
        lc  = 0;
        fr  = 1'b0;
      end
    end
    dp_active  <= act;
    lowcnt     <= lc;
    first_resp <= fr;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    HRESET = 1'b1;
    hsel   = 1'b0;
    use0   = 1'b0;
    HTRANS = HTRANS_IDLE;
    HADDR  = 32'h0;
    HWDATA = 32'h0;
    HSIZE  = HSIZE_WORD;
    HWRITE = 1'b0;
    #3;
    check("rst_rdy2",   32'(ro2), 32'd1);
    check("rst_resp2",  32'(rs2), 32'd0);
    check("rst_rdata2", rd2, 32'h0);
    check("rst_rdy0",   32'(ro0), 32'd1);
    check("rst_rdata0", rd0, 32'h0);
    repeat (2) @(posedge HCLK);
    #1;
    HRESET = 1'b0;

    // Word write then read-back, two wait states each
    issue(1'b1, 32'h010, HSIZE_WORD, 32'hDEADBEEF, HTRANS_NONSEQ, 1'b1);
    issue(1'b0, 32'h010, HSIZE_WORD, 32'h0,        HTRANS_NONSEQ, 1'b1);
    drain();

    // Byte write into the top lane
    issue(1'b1, 32'h013, HSIZE_BYTE, 32'hAA000000, HTRANS_NONSEQ, 1'b1);
    issue(1'b0, 32'h010, HSIZE_WORD, 32'h0,        HTRANS_NONSEQ, 1'b1);
    drain();

    // Upper halfword write over a known word
    issue(1'b1, 32'h014, HSIZE_WORD, 32'h11223344, HTRANS_NONSEQ, 1'b1);
    issue(1'b1, 32'h016, HSIZE_HALF, 32'h55660000, HTRANS_SEQ,    1'b1);
    issue(1'b0, 32'h014, HSIZE_WORD, 32'h0,        HTRANS_NONSEQ, 1'b1);
    drain();

    // Misaligned halfword must not disturb memory
    issue(1'b1, 32'h011, HSIZE_HALF, 32'hFFFFFFFF, HTRANS_NONSEQ, 1'b1);
    issue(1'b0, 32'h010, HSIZE_WORD, 32'h0,        HTRANS_NONSEQ, 1'b1);
    drain();

    // Out-of-range and oversize, back to back
    issue(1'b0, 32'h400, HSIZE_WORD, 32'h0, HTRANS_NONSEQ, 1'b1);
    issue(1'b1, 32'h020, 3'd3,       32'h0, HTRANS_NONSEQ, 1'b1);
    drain();

    // Zero-wait streaming on the second instance
    use0 = 1'b1;
    issue(1'b1, 32'h000, HSIZE_WORD, 32'd1, HTRANS_NONSEQ, 1'b1);
    issue(1'b1, 32'h004, HSIZE_WORD, 32'd2, HTRANS_SEQ,    1'b1);
    issue(1'b1, 32'h008, HSIZE_WORD, 32'd3, HTRANS_SEQ,    1'b1);
    issue(1'b1, 32'h00C, HSIZE_WORD, 32'd4, HTRANS_SEQ,    1'b1);
    issue(1'b0, 32'h000, HSIZE_WORD, 32'h0, HTRANS_NONSEQ, 1'b1);
    idle_sel(1, HTRANS_IDLE);
    issue(1'b0, 32'h004, HSIZE_WORD, 32'h0, HTRANS_NONSEQ, 1'b1);
    idle_sel(1, HTRANS_BUSY);
    issue(1'b0, 32'h008, HSIZE_WORD, 32'h0, HTRANS_SEQ,    1'b1);
    issue(1'b0, 32'h00C, HSIZE_WORD, 32'h0, HTRANS_SEQ,    1'b1);
    issue(1'b1, 32'h002, HSIZE_WORD, 32'h0, HTRANS_NONSEQ, 1'b1);
    drain();
    check("stream_rdy0", 32'(ro0), 32'd1);
    use0 = 1'b0;

    // Reset during the first wait cycle of a write
    issue(1'b1, 32'h020, HSIZE_WORD, 32'hCAFEF00D, HTRANS_NONSEQ, 1'b1);
    drain();
    issue(1'b1, 32'h020, HSIZE_WORD, 32'h12345678, HTRANS_NONSEQ, 1'b0);
    check("mid_wait_rdy", 32'(ro2), 32'd0);
    #1;
    HRESET = 1'b1;
    #1;
    check("mid_rst_rdy",   32'(ro2), 32'd1);
    check("mid_rst_rdata", rd2, 32'h0);
    check("mid_rst_resp",  32'(rs2), 32'd0);
    @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    issue(1'b0, 32'h020, HSIZE_WORD, 32'h0, HTRANS_NONSEQ, 1'b1);
    drain();

    check("sb_left", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
